// File: rtl/cic_seq_pkg.sv
// Shared types and limits for the CIC decimation sequencer.
// Imported by cic_seq_phase_ctr and cic_decim_sequencer.
package cic_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int PIPE_LAT_MIN  = 1;
    localparam int PIPE_LAT_MAX  = 8;
    localparam int OUT_DEPTH_MIN = 1;
    localparam int OUT_DEPTH_MAX = 15;

    // Bits needed for a counter that must reach depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cic_seq_phase_ctr.sv
// Decimation phase counter: latches the run ratio and flags
// the sample that completes a decimation period.
module cic_seq_phase_ctr
    import cic_seq_pkg::*;
#(
    parameter int RATIO_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic                   accept_i,
    input  logic [RATIO_WIDTH-1:0] ratio_i,
    output logic [RATIO_WIDTH-1:0] phase_o,
    output logic                   last_o
);

    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] phase_q;

    // Stop discards a partial period even if a sample lands with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ratio_q <= '0;
            phase_q <= '0;
        end else if (load_i) begin
            ratio_q <= ratio_i;
            phase_q <= '0;
        end else if (clear_i) begin
            phase_q <= '0;
        end else if (accept_i) begin
            phase_q <= last_o ? '0
                              : phase_q + RATIO_WIDTH'(1);
        end
    end

    assign last_o  = (phase_q == ratio_q - RATIO_WIDTH'(1));
    assign phase_o = phase_q;

endmodule

// File: rtl/cic_decim_sequencer.sv
// Enable sequencer for the CIC decimation chain with credit-based
// output backpressure. Optional CIC_SEQ_STATS_EN adds stat_out_cnt_o.
module cic_decim_sequencer
    import cic_seq_pkg::*;
#(
    parameter int RATIO_WIDTH = 4,
    parameter int PIPE_LAT    = 2,
    parameter int OUT_DEPTH   = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [RATIO_WIDTH-1:0] ratio_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic                   integ_ena_o,
    output logic                   decim_ena_o,
    output logic                   comb_ena_o,
    output logic [RATIO_WIDTH-1:0] phase_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   busy_o,
    output logic                   cfg_err_o
`ifdef CIC_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_out_cnt_o
`endif
);

    localparam logic [CNT_WIDTH:0] DEPTH_C =
        (CNT_WIDTH + 1)'(OUT_DEPTH);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic                 last_w;
    logic                 accept_w;
    logic                 load_w;
    logic                 halt_w;
    logic                 arrive_w;
    logic                 take_w;
    logic                 comb_q;
    logic                 cfg_err_q;
    logic [CNT_WIDTH-1:0] inflight_q;
    logic [CNT_WIDTH-1:0] pending_q;
    logic [CNT_WIDTH:0]   credit_w;

    assign load_w   = (state_q == IDLE) & start_i
                    & (ratio_i != '0);
    assign halt_w   = (state_q == RUN) & stop_i;
    assign credit_w = {1'b0, inflight_q} + {1'b0, pending_q};

    // Only the period-closing sample needs an output credit.
    assign s_ready_o   = (state_q == RUN)
                       & ~(last_w & (credit_w >= DEPTH_C));
    assign accept_w    = s_valid_i & s_ready_o;
    assign integ_ena_o = accept_w;
    assign decim_ena_o = accept_w & last_w;
    assign comb_ena_o  = comb_q;
    assign m_valid_o   = (pending_q != '0);
    assign take_w      = m_valid_o & m_ready_i;
    assign busy_o      = (state_q != IDLE);
    assign cfg_err_o   = cfg_err_q;

    cic_seq_phase_ctr #(
        .RATIO_WIDTH (RATIO_WIDTH)
    ) u_phase (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (load_w),
        .clear_i  (halt_w),
        .accept_i (accept_w),
        .ratio_i  (ratio_i),
        .phase_o  (phase_o),
        .last_o   (last_w)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Run control: drain leaves only when nothing is outstanding
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load_w) state_d = RUN;
            RUN:     if (stop_i) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0 && pending_q == '0)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Config error flag and comb enable stage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_err_q <= 1'b0;
            comb_q    <= 1'b0;
        end else begin
            comb_q <= decim_ena_o;
            if (state_q == IDLE && start_i)
                cfg_err_q <= (ratio_i == '0);
        end
    end

    generate
        if (PIPE_LAT == 1) begin : g_lat1
            assign arrive_w = decim_ena_o;
        end else begin : g_latn
            logic [PIPE_LAT-2:0] dly_q;
            logic [PIPE_LAT-1:0] sh_w;
            assign sh_w     = {dly_q, decim_ena_o};
            assign arrive_w = sh_w[PIPE_LAT-1];
            // Age read pulses toward the datapath output
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) dly_q <= '0;
                else          dly_q <= sh_w[PIPE_LAT-2:0];
            end
        end
    endgenerate

    // In-flight and pending result counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
            pending_q  <= '0;
        end else begin
            unique case ({decim_ena_o, arrive_w})
                2'b10:   inflight_q <= inflight_q + CNT_WIDTH'(1);
                2'b01:   inflight_q <= inflight_q - CNT_WIDTH'(1);
                default: ;
            endcase
            unique case ({arrive_w, take_w})
                2'b10:   pending_q <= pending_q + CNT_WIDTH'(1);
                2'b01:   pending_q <= pending_q - CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef CIC_SEQ_STATS_EN
    logic [15:0] stat_q;

    // Saturating output handshake count, cleared per run
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stat_q <= '0;
        else if (load_w)
            stat_q <= '0;
        else if (take_w && stat_q != 16'hFFFF)
            stat_q <= stat_q + 16'd1;
    end

    assign stat_out_cnt_o = stat_q;
`endif

    a_credit: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        credit_w <= DEPTH_C
    );

    a_params: assert property (
        @(posedge clk_i)
        CNT_WIDTH >= cnt_width(OUT_DEPTH)
        && PIPE_LAT >= PIPE_LAT_MIN
        && PIPE_LAT <= PIPE_LAT_MAX
        && OUT_DEPTH >= OUT_DEPTH_MIN
        && OUT_DEPTH <= OUT_DEPTH_MAX
    );

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Randomized scoreboard bench for cic_decim_sequencer.
// Reference model tracks issued results as a queue of issue cycles.
module tb_cic_decim_sequencer;

    localparam int RW = 4;
    localparam int PL = 2;
    localparam int OD = 2;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [RW-1:0] ratio_i = '0;
    logic          s_valid_i = 1'b0;
    logic          m_ready_i = 1'b0;
    logic          s_ready_o;
    logic          integ_ena_o;
    logic          decim_ena_o;
    logic          comb_ena_o;
    logic [RW-1:0] phase_o;
    logic          m_valid_o;
    logic          busy_o;
    logic          cfg_err_o;
`ifdef CIC_SEQ_STATS_EN
    logic [15:0]   stat_out_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    cic_decim_sequencer #(
        .RATIO_WIDTH (RW),
        .PIPE_LAT    (PL),
        .OUT_DEPTH   (OD),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .ratio_i     (ratio_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .integ_ena_o (integ_ena_o),
        .decim_ena_o (decim_ena_o),
        .comb_ena_o  (comb_ena_o),
        .phase_o     (phase_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o),
        .cfg_err_o   (cfg_err_o)
`ifdef CIC_SEQ_STATS_EN
        ,
        .stat_out_cnt_o (stat_out_cnt_o)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: 0 idle, 1 run, 2 drain
    int m_st = 0;
    int m_r = 0;
    int m_cnt = 0;
    int m_cfg = 0;
    int m_prev = 0;
    int m_hs = 0;
    int m_q[$];
    int sb_q[$];

    int obs_acc = 0;
    int obs_dec = 0;
    int obs_hs = 0;

    task automatic chk(input string nm, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_r = 0; m_cnt = 0;
        m_cfg = 0; m_prev = 0; m_hs = 0;
        m_q.delete();
        sb_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready_o, 0);
        chk({tag, "_integ"}, integ_ena_o, 0);
        chk({tag, "_decim"}, decim_ena_o, 0);
        chk({tag, "_comb"}, comb_ena_o, 0);
        chk({tag, "_phase"}, phase_o, 0);
        chk({tag, "_m_valid"}, m_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_cfg_err"}, cfg_err_o, 0);
    endtask

    task automatic step(input bit st, input bit sp,
                        input int ra, input bit sv,
                        input bit mr);
        bit e_last, e_rdy, e_acc, e_dec, e_mv, empty;
        @(negedge clk_i);
        start_i   = st;
        stop_i    = sp;
        ratio_i   = RW'(ra);
        s_valid_i = sv;
        m_ready_i = mr;
        #1;
        e_last = (m_st == 1) && (m_cnt == m_r - 1);
        e_rdy  = (m_st == 1) && !(e_last && m_q.size() >= OD);
        e_acc  = sv && e_rdy;
        e_dec  = e_acc && e_last;
        e_mv   = (m_q.size() > 0) && (cyc - m_q[0] >= PL);
        chk("s_ready", s_ready_o, int'(e_rdy));
        chk("integ", integ_ena_o, int'(e_acc));
        chk("decim", decim_ena_o, int'(e_dec));
        chk("comb", comb_ena_o, m_prev);
        chk("phase", phase_o, m_cnt);
        chk("m_valid", m_valid_o, int'(e_mv));
        chk("busy", busy_o, int'(m_st != 0));
        chk("cfg_err", cfg_err_o, m_cfg);
        if (e_dec) sb_q.push_back(cyc + PL);
        obs_acc += int'(integ_ena_o);
        obs_dec += int'(decim_ena_o);
        obs_hs  += int'(m_valid_o && mr);
        @(posedge clk_i);
        empty = (m_q.size() == 0);
        if (e_mv && mr) begin
            void'(m_q.pop_front());
            m_hs++;
        end
        if (e_dec) m_q.push_back(cyc);
        case (m_st)
            0: if (st) begin
                if (ra == 0) m_cfg = 1;
                else begin
                    m_r = ra; m_cnt = 0; m_cfg = 0;
                    m_st = 1; m_hs = 0;
                end
            end
            1: begin
                if (e_acc) m_cnt = e_last ? 0 : m_cnt + 1;
                if (sp) begin m_st = 2; m_cnt = 0; end
            end
            default: if (empty) m_st = 0;
        endcase
        m_prev = int'(e_dec);
        cyc++;
    endtask

    task automatic drain();
        step(0, 1, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
    endtask

    task automatic clr_obs();
        obs_acc = 0; obs_dec = 0; obs_hs = 0;
    endtask

    // Scoreboard monitor: every output handshake must match a result
    initial begin
        int r;
        forever begin
            @(negedge clk_i);
            #3;
            if (rst_n_i && m_valid_o && m_ready_i) begin
                chk("sb_nonempty", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    r = sb_q.pop_front();
                    chk("sb_latency", int'(cyc >= r), 1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=done",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk_zero("rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // R=4 continuous stream
        step(1, 0, 4, 0, 1);
        clr_obs();
        repeat (14) step(0, 0, 0, 1, 1);
        chk("r4_decims", obs_dec, 3);
        drain();

        // R=1 backpressure with OUT_DEPTH credits
        step(1, 0, 1, 0, 0);
        clr_obs();
        repeat (6) step(0, 0, 0, 1, 0);
        chk("bp_first", obs_acc, OD);
        step(0, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1, 0);
        chk("bp_total", obs_acc, OD + 1);
        drain();

        // ratio 0 is rejected, then a legal start
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("cfg_err_set", cfg_err_o, 1);
        step(1, 0, 3, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("cfg_err_clr", cfg_err_o, 0);
        chk("busy_run", busy_o, 1);
        drain();

        // stop with a partial period
        step(1, 0, 4, 0, 1);
        clr_obs();
        repeat (6) step(0, 0, 0, 1, 1);
        drain();
        chk("part_decims", obs_dec, 1);
        chk("part_taken", obs_hs, 1);

        // stop together with the closing sample
        step(1, 0, 4, 0, 1);
        clr_obs();
        repeat (3) step(0, 0, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        chk("stopwrap_decims", obs_dec, 1);
        chk("stopwrap_taken", obs_hs, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int ra;
            ra = ($urandom_range(0, 7) == 0)
               ? 0 : int'($urandom_range(1, 6));
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0,
                 ra,
                 ($urandom % 4) != 0,
                 ($urandom % 3) != 0);
        end
        drain();
        repeat (10) step(0, 0, 0, 0, 1);
        chk("sb_empty", sb_q.size(), 0);
`ifdef CIC_SEQ_STATS_EN
        chk("stats", stat_out_cnt_o, m_hs);
`endif

        // reset mid-run with a pending result
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_rst_valid", m_valid_o, 1);
        @(negedge clk_i);
        start_i = 0; stop_i = 0;
        s_valid_i = 0; m_ready_i = 0;
        #2 rst_n_i = 1'b0;
        #1;
        chk_zero("mid_rst");
        model_reset();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_valid", m_valid_o, 0);
        @(posedge clk_i);
        cyc++;
        repeat (3) step(0, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
